// File: rtl/display_streamer.sv
// rtl/display_streamer.sv - frames the microwave display buffer and heater level into 33-byte streams
// Frame layout: display bytes 31 down to 0, then trailer {4'hA, heat}.
module display_streamer #(
  parameter int AUTO_SEND = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] display,
  input  logic [3:0]   heat,
  input  logic         frame_req,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         tx_last,
  output logic         busy,
  output logic [7:0]   frame_count,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [255:0]   r_shadow;
  logic [255:0]   r_last_sent;
  logic [3:0]     r_heat;
  logic [5:0]     r_idx;
  logic           r_pending;
  logic           r_overrun;
  logic [7:0]     r_frame_count;
  logic [7:0]     r_tx_data;
  logic           r_tx_valid;
  logic           r_tx_last;

  logic           w_changed;
  logic           w_start;
  logic [5:0]     w_next_idx;
  logic [7:0]     w_next_byte;

  assign w_changed   = (AUTO_SEND != 0) && (display != r_last_sent);
  assign w_start     = frame_req || r_pending || w_changed;
  assign w_next_idx  = r_idx + 6'd1;
  // Index k of the frame carries shadow byte 31-k; ~k[4:0] is that byte number.
  assign w_next_byte = w_next_idx[5] ? {4'hA, r_heat}
                                     : r_shadow[{~w_next_idx[4:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_last_sent   <= '0;
      r_heat        <= '0;
      r_idx         <= '0;
      r_pending     <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= SEND;
            r_shadow    <= display;
            r_heat      <= heat;
            r_last_sent <= display;
            r_pending   <= 1'b0;
            r_idx       <= '0;
            r_tx_data   <= display[255:248];
            r_tx_valid  <= 1'b1;
            r_tx_last   <= 1'b0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (r_idx == 6'd32) begin
              r_state       <= DONE;
              r_idx         <= '0;
              r_tx_data     <= '0;
              r_tx_valid    <= 1'b0;
              r_tx_last     <= 1'b0;
              r_frame_count <= r_frame_count + 8'd1;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              r_tx_last <= (w_next_idx == 6'd32);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Requests arriving mid-frame are queued once; a second explicit one is lost.
      if (r_state != IDLE) begin
        if (frame_req) begin
          if (r_pending) r_overrun <= 1'b1;
          else           r_pending <= 1'b1;
        end
        if (w_changed) r_pending <= 1'b1;
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign tx_last     = r_tx_last;
  assign busy        = (r_state != IDLE);
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_display_streamer.sv
// tb/tb_display_streamer.sv - directed self-checking bench for display_streamer
module tb_display_streamer;

  logic         clk = 1'b0;
  logic         reset, reset0;
  logic [255:0] display;
  logic [3:0]   heat;
  logic         frame_req, frame_req0;
  logic         tx_ready;

  logic [7:0]   tx_data, tx_data0;
  logic         tx_valid, tx_valid0;
  logic         tx_last, tx_last0;
  logic         busy, busy0;
  logic [7:0]   frame_count, frame_count0;
  logic         overrun, overrun0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cap_data [0:32];
  logic       cap_last [0:32];
  int         cap_cycles;
  int         cap_stall_err;
  bit         cap_timeout;

  always #5 clk = ~clk;

  display_streamer #(.AUTO_SEND(1)) dut (
    .clk(clk), .reset(reset), .display(display), .heat(heat),
    .frame_req(frame_req), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .busy(busy),
    .frame_count(frame_count), .overrun(overrun)
  );

  display_streamer #(.AUTO_SEND(0)) dut0 (
    .clk(clk), .reset(reset0), .display(display), .heat(heat),
    .frame_req(frame_req0), .tx_ready(tx_ready), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_last(tx_last0), .busy(busy0),
    .frame_count(frame_count0), .overrun(overrun0)
  );

  function automatic logic [255:0] fill(input logic [7:0] b);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = b;
    return v;
  endfunction

  function automatic logic [255:0] pat(input logic [7:0] base);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[8*k +: 8] = base + 8'(k);
    return v;
  endfunction

  // Records one frame; called at a negedge, returns at the negedge after the last transfer.
  task automatic capture_frame(input bit toggle, input int change_at,
                               input logic [255:0] new_disp, input logic [3:0] new_heat);
    int n = 0;
    int budget = 0;
    logic stalled = 1'b0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    cap_cycles = 0; cap_stall_err = 0; cap_timeout = 0;
    while (!tx_valid && budget < 10) begin @(negedge clk); budget++; end
    while (n < 33 && budget < 300) begin
      if (tx_valid) begin
        cap_cycles++;
        if (stalled && (tx_data !== pd || tx_last !== pl)) cap_stall_err++;
        tx_ready = toggle ? (cap_cycles % 2 == 0) : 1'b1;
        if (tx_ready) begin
          cap_data[n] = tx_data; cap_last[n] = tx_last;
          if (n == change_at) begin display = new_disp; heat = new_heat; end
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; pd = tx_data; pl = tx_last;
        end
      end
      @(negedge clk); budget++;
    end
    if (n < 33) cap_timeout = 1;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 0; reset0 = 0; frame_req = 0; frame_req0 = 0; tx_ready = 1;
    display = '0; heat = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", tx_data); end
    n_cmp++; if (tx_last !== 1'b0) begin n_err++; $display("FAIL rst_last got=%b exp=0", tx_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", frame_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    display = fill(8'h41); heat = 4'h3;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold got=%b exp=0", tx_valid); end
    reset = 1;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL rel_valid got=%b exp=1", tx_valid); end
    n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL rel_data got=%h exp=41", tx_data); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rel_busy got=%b exp=1", busy); end
  endtask

  task automatic test_auto_frame();
    logic [7:0] exp;
    capture_frame(0, -1, '0, '0);
    n_cmp++; if (cap_timeout) begin n_err++; $display("FAIL auto_timeout got=1 exp=0"); end
    n_cmp++; if (cap_cycles !== 33) begin n_err++; $display("FAIL auto_cycles got=%0d exp=33", cap_cycles); end
    for (int i = 0; i < 33; i++) begin
      exp = (i < 32) ? 8'h41 : 8'hA3;
      n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL auto_byte%0d got=%h exp=%h", i, cap_data[i], exp); end
      n_cmp++; if (cap_last[i] !== (i == 32)) begin n_err++; $display("FAIL auto_last%0d got=%b exp=%b", i, cap_last[i], i == 32); end
    end
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL auto_done got=v%b/b%b exp=v0/b1", tx_valid, busy); end
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL auto_done_data got=%h exp=00", tx_data); end
    n_cmp++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL auto_count got=%0d exp=1", frame_count); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL auto_idle got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    display = pat(8'h00); heat = 4'h5;
    capture_frame(1, -1, '0, '0);
    n_cmp++; if (cap_timeout) begin n_err++; $display("FAIL bp_timeout got=1 exp=0"); end
    n_cmp++; if (cap_cycles !== 66) begin n_err++; $display("FAIL bp_cycles got=%0d exp=66", cap_cycles); end
    n_cmp++; if (cap_stall_err !== 0) begin n_err++; $display("FAIL bp_stall got=%0d exp=0", cap_stall_err); end
    for (int i = 0; i < 33; i++) begin
      exp = (i < 32) ? 8'(31 - i) : 8'hA5;
      n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL bp_byte%0d got=%h exp=%h", i, cap_data[i], exp); end
      n_cmp++; if (cap_last[i] !== (i == 32)) begin n_err++; $display("FAIL bp_last%0d got=%b exp=%b", i, cap_last[i], i == 32); end
    end
    n_cmp++; if (frame_count !== 8'd2) begin n_err++; $display("FAIL bp_count got=%0d exp=2", frame_count); end
    @(negedge clk);
  endtask

  task automatic test_midframe();
    logic [7:0] exp;
    display = fill(8'h11); heat = 4'h1;
    capture_frame(0, 10, fill(8'h22), 4'h7);
    for (int i = 0; i < 33; i++) begin
      exp = (i < 32) ? 8'h11 : 8'hA1;
      n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL mid1_byte%0d got=%h exp=%h", i, cap_data[i], exp); end
    end
    n_cmp++; if (frame_count !== 8'd3) begin n_err++; $display("FAIL mid1_count got=%0d exp=3", frame_count); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_idle got=%b exp=0", busy); end
    capture_frame(0, -1, '0, '0);
    n_cmp++; if (cap_timeout) begin n_err++; $display("FAIL mid2_timeout got=1 exp=0"); end
    for (int i = 0; i < 33; i++) begin
      exp = (i < 32) ? 8'h22 : 8'hA7;
      n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL mid2_byte%0d got=%h exp=%h", i, cap_data[i], exp); end
    end
    n_cmp++; if (frame_count !== 8'd4) begin n_err++; $display("FAIL mid2_count got=%0d exp=4", frame_count); end
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_no_third got=%b exp=0", busy); end
  endtask

  task automatic test_coincident();
    int busy_cnt = 0;
    display = fill(8'h55); heat = 4'h2; frame_req = 1;
    @(negedge clk);
    frame_req = 0;
    capture_frame(0, -1, '0, '0);
    n_cmp++; if (cap_data[0] !== 8'h55 || cap_data[32] !== 8'hA2) begin n_err++; $display("FAIL coin_bytes got=%h/%h exp=55/a2", cap_data[0], cap_data[32]); end
    n_cmp++; if (frame_count !== 8'd5) begin n_err++; $display("FAIL coin_count got=%0d exp=5", frame_count); end
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin if (busy) busy_cnt++; @(negedge clk); end
    n_cmp++; if (busy_cnt !== 0) begin n_err++; $display("FAIL coin_extra got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_overrun();
    int b = 0;
    int busy_cnt = 0;
    frame_req = 1; @(negedge clk); frame_req = 0;
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_start got=%b exp=1", tx_valid); end
    @(negedge clk); frame_req = 1; @(negedge clk); frame_req = 0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first got=%b exp=0", overrun); end
    @(negedge clk); frame_req = 1; @(negedge clk); frame_req = 0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_second got=%b exp=1", overrun); end
    while (frame_count !== 8'd7 && b < 200) begin @(negedge clk); b++; end
    n_cmp++; if (frame_count !== 8'd7) begin n_err++; $display("FAIL ovr_count got=%0d exp=7", frame_count); end
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin if (busy) busy_cnt++; @(negedge clk); end
    n_cmp++; if (busy_cnt !== 0 || frame_count !== 8'd7) begin n_err++; $display("FAIL ovr_extra got=%0d/%0d exp=0/7", busy_cnt, frame_count); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_back_to_back();
    int b = 0;
    int gap = 0;
    logic prev = 1'b1;
    frame_req = 1;
    while (!tx_valid && b < 10) begin @(negedge clk); b++; end
    n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL b2b_start got=%b exp=1", tx_valid); end
    for (int c = 1; c <= 100 && gap == 0; c++) begin
      @(negedge clk);
      if (tx_valid && !prev) gap = c;
      prev = tx_valid;
    end
    frame_req = 0;
    n_cmp++; if (gap !== 35) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=35", gap); end
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_abort();
    int b = 0;
    logic [7:0] exp;
    display = fill(8'h33); heat = 4'h9;
    while (!tx_valid && b < 10) begin @(negedge clk); b++; end
    repeat (20) @(negedge clk);
    n_cmp++; if (tx_data !== 8'h33 || tx_valid !== 1'b1) begin n_err++; $display("FAIL abort_pre got=%h/v%b exp=33/v1", tx_data, tx_valid); end
    reset = 0;
    #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL abort_state got=%h/b%b exp=00/b0", tx_data, busy); end
    n_cmp++; if (frame_count !== 8'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL abort_count got=%0d/o%b exp=0/o0", frame_count, overrun); end
    display = pat(8'h80); heat = 4'hC;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h9F) begin n_err++; $display("FAIL abort_restart got=v%b/%h exp=v1/9f", tx_valid, tx_data); end
    capture_frame(0, -1, '0, '0);
    for (int i = 0; i < 33; i++) begin
      exp = (i < 32) ? 8'(8'h9F - i) : 8'hAC;
      n_cmp++; if (cap_data[i] !== exp) begin n_err++; $display("FAIL abort_byte%0d got=%h exp=%h", i, cap_data[i], exp); end
    end
    n_cmp++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL abort_count2 got=%0d exp=1", frame_count); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    reset = 0; tx_ready = 1;
    n_cmp++; if (frame_count0 !== 8'd0 || overrun0 !== 1'b0 || tx_valid0 !== 1'b0) begin n_err++; $display("FAIL wrap_rst got=%0d/o%b/v%b exp=0/o0/v0", frame_count0, overrun0, tx_valid0); end
    reset0 = 1;
    display = fill(8'h77);
    repeat (5) @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL wrap_noauto got=%b exp=0", busy0); end
    for (int i = 0; i < 256; i++) begin
      frame_req0 = 1;
      @(negedge clk);
      frame_req0 = 0;
      repeat (34) @(negedge clk);
      if (i == 0) begin
        n_cmp++; if (frame_count0 !== 8'd1) begin n_err++; $display("FAIL wrap_first got=%0d exp=1", frame_count0); end
      end
      if (i == 254) begin
        n_cmp++; if (frame_count0 !== 8'd255) begin n_err++; $display("FAIL wrap_255 got=%0d exp=255", frame_count0); end
      end
    end
    n_cmp++; if (frame_count0 !== 8'd0) begin n_err++; $display("FAIL wrap_zero got=%0d exp=0", frame_count0); end
    n_cmp++; if (overrun0 !== 1'b0 || busy0 !== 1'b0) begin n_err++; $display("FAIL wrap_flags got=o%b/b%b exp=o0/b0", overrun0, busy0); end
  endtask

  initial begin
    test_reset();
    test_auto_frame();
    test_backpressure();
    test_midframe();
    test_coincident();
    test_overrun();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
